ps2_keyboard_tx: RTL

- PS/2 device-side transmitter (keyboard emulator).
- Accepts key press/release events, encodes them as set-2 scan-code byte sequences (make = code; break = F0 then code), and serializes each byte as an 11-bit PS/2 frame on ps2_clk/ps2_data.
- Feeds the existing PS/2 receive path and keyboard display logic for loopback testing and simulated typing.

---
 rtl/ps2_keyboard_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter (keyboard emulator).
// Key events are queued in a small FIFO, expanded to set-2 make/break byte
// sequences, and serialized as 11-bit PS/2 frames on ps2_clk/ps2_data.
// Optional build macro: PS2_TX_ASCII_MAP_EN translates ASCII key_code values
// to set-2 codes at push time and drops unmapped characters.
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYC    = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_release,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] break_cnt
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DW-1:0] HALF      = DW'(CLK_DIV);
  localparam logic [DW-1:0] SLOT_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t          state, state_next;
  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_empty;
  logic            push, pop;
  logic            map_hit;
  logic [7:0]      push_code;
  logic [8:0]      rd_entry;

  logic [7:0]      tx_byte, code_q;
  logic            pending_code, cur_release;
  logic [2:0]      bit_idx;
  logic [DW-1:0]   div_cnt;
  logic [15:0]     gap_cnt;
  logic            slot_end, gap_end, in_slot;
  logic            load_code, inc_break, done_now;
  logic            line_clk, line_data;

`ifdef PS2_TX_ASCII_MAP_EN
  // ASCII digit / lowercase letter to set-2 make code; bit 8 flags a hit
  function automatic logic [8:0] ascii_to_set2(input logic [7:0] a);
    logic [8:0] r;
    r = '0;
    case (a)
      8'h30: r = 9'h145;  8'h31: r = 9'h116;  8'h32: r = 9'h11E;
      8'h33: r = 9'h126;  8'h34: r = 9'h125;  8'h35: r = 9'h12E;
      8'h36: r = 9'h136;  8'h37: r = 9'h13D;  8'h38: r = 9'h13E;
      8'h39: r = 9'h146;
      8'h61: r = 9'h11C;  8'h62: r = 9'h132;  8'h63: r = 9'h121;
      8'h64: r = 9'h123;  8'h65: r = 9'h124;  8'h66: r = 9'h12B;
      8'h67: r = 9'h134;  8'h68: r = 9'h133;  8'h69: r = 9'h143;
      8'h6A: r = 9'h13B;  8'h6B: r = 9'h142;  8'h6C: r = 9'h14B;
      8'h6D: r = 9'h13A;  8'h6E: r = 9'h131;  8'h6F: r = 9'h144;
      8'h70: r = 9'h14D;  8'h71: r = 9'h115;  8'h72: r = 9'h12D;
      8'h73: r = 9'h11B;  8'h74: r = 9'h12C;  8'h75: r = 9'h13C;
      8'h76: r = 9'h12A;  8'h77: r = 9'h11D;  8'h78: r = 9'h122;
      8'h79: r = 9'h135;  8'h7A: r = 9'h11A;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {map_hit, push_code} = ascii_to_set2(key_code);
`else
  assign map_hit   = 1'b1;
  assign push_code = key_code;
`endif

  assign fifo_empty = (count == '0);
  assign key_ready  = (count != FULL_CNT);
  assign push       = key_valid && key_ready && map_hit;
  assign rd_entry   = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {key_release, push_code};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign in_slot  = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
  assign slot_end = (div_cnt == SLOT_LAST);
  assign gap_end  = (gap_cnt == GAP_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, FIFO pop, frame sequencing and line values for the current slot
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_code  = 1'b0;
    inc_break  = 1'b0;
    done_now   = 1'b0;
    line_clk   = 1'b1;
    line_data  = 1'b1;
    if (in_slot) line_clk = (div_cnt < HALF);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_data = 1'b0;
        if (slot_end) state_next = DATA;
      end
      DATA: begin
        line_data = tx_byte[bit_idx];
        if (slot_end && bit_idx == 3'd7) state_next = PARITY;
      end
      PARITY: begin
        line_data = ~^tx_byte;
        if (slot_end) state_next = STOP;
      end
      STOP: begin
        line_data = 1'b1;
        if (slot_end) begin
          done_now   = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (pending_code) begin
            load_code  = 1'b1;
            state_next = START;
          end else begin
            inc_break  = cur_release;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte selection, slot/bit/gap counters, break counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte      <= '0;
      code_q       <= '0;
      pending_code <= 1'b0;
      cur_release  <= 1'b0;
      bit_idx      <= '0;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      break_cnt    <= '0;
    end else begin
      if (pop) begin
        tx_byte      <= rd_entry[8] ? 8'hF0 : rd_entry[7:0];
        code_q       <= rd_entry[7:0];
        pending_code <= rd_entry[8];
        cur_release  <= rd_entry[8];
      end
      if (load_code) begin
        tx_byte      <= code_q;
        pending_code <= 1'b0;
      end
      if (inc_break) break_cnt <= break_cnt + 1'b1;
      div_cnt <= (in_slot && !slot_end) ? div_cnt + 1'b1 : '0;
      if (state != DATA)  bit_idx <= '0;
      else if (slot_end)  bit_idx <= bit_idx + 1'b1;
      gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Registered line drivers: lines follow the FSM one cycle later, so a
  // push at edge T pops at T+1 and shows the start bit from T+2
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      ps2_clk  <= line_clk;
      ps2_data <= line_data;
      tx_done  <= done_now;
    end
  end

endmodule
